// File: rtl/threshold_discriminator.sv
// rtl/threshold_discriminator.sv - threshold crossing trigger with pulse peak/width measurement, hold-off and single-entry event slot
// Optional hysteresis on the falling edge is enabled with macro HYSTERESIS_EN.
module threshold_discriminator #(
   parameter int N_P       = 12,
   parameter int W_WIDTH   = 16,
   parameter int HOLDOFF   = 32,
   parameter int MIN_WIDTH = 2,
   parameter int HYST      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_valid,
   input  logic [N_P-1:0]     sample,
   input  logic [N_P-1:0]     threshold,
   output logic               trig,
   output logic               busy,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [N_P-1:0]     ev_peak,
   output logic [W_WIDTH-1:0] ev_width,
   output logic [15:0]        drop_count
);

   typedef enum logic [1:0] {S_IDLE, S_ABOVE, S_HOLD} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [N_P-1:0]       r_fall;
   logic [N_P-1:0]       r_peak;
   logic [W_WIDTH-1:0]   r_width;
   logic [31:0]          r_hold_cnt;
   logic                 r_trig;
   logic                 r_busy;
   logic                 r_ev_valid;
   logic [N_P-1:0]       r_ev_peak;
   logic [W_WIDTH-1:0]   r_ev_width;
   logic [15:0]          r_drop;

   logic                 w_start;
   logic                 w_above;
   logic                 w_end;
   logic                 w_post;
   logic                 w_trig_nxt;
   logic                 w_busy_nxt;
   logic [N_P-1:0]       w_fall_lvl;

`ifdef HYSTERESIS_EN
   // One extra bit keeps threshold - HYST from wrapping before the clamp.
   localparam logic signed [N_P:0] FALL_MIN = {2'b11, {(N_P-1){1'b0}}};
   logic signed [N_P:0]  w_fall_ext;
   always_comb begin
      w_fall_ext = $signed({threshold[N_P-1], threshold}) - $signed((N_P+1)'(HYST));
      w_fall_lvl = threshold;
      if (w_fall_ext < FALL_MIN) w_fall_lvl = FALL_MIN[N_P-1:0];
      else                       w_fall_lvl = w_fall_ext[N_P-1:0];
   end
`else
   assign w_fall_lvl = threshold;
`endif

   assign w_start = (r_state == S_IDLE) && sample_valid && ($signed(sample) > $signed(threshold));
   assign w_above = $signed(sample) > $signed(r_fall);
   assign w_end   = (r_state == S_ABOVE) && sample_valid && !w_above;
   assign w_post  = w_end && (r_width >= W_WIDTH'(MIN_WIDTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next_state = S_ABOVE;
         S_ABOVE: if (w_end)   w_next_state = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
         S_HOLD:  if (r_hold_cnt <= 32'd1) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_trig_nxt = w_start;
      w_busy_nxt = (w_next_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_trig     <= 1'b0;
         r_busy     <= 1'b0;
         r_fall     <= '0;
         r_peak     <= '0;
         r_width    <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_trig <= w_trig_nxt;
         r_busy <= w_busy_nxt;
         if (w_start) begin
            r_fall  <= w_fall_lvl;
            r_peak  <= sample;
            r_width <= W_WIDTH'(1);
         end else if ((r_state == S_ABOVE) && sample_valid && w_above) begin
            if (r_width != {W_WIDTH{1'b1}}) r_width <= r_width + 1'b1;
            if ($signed(sample) > $signed(r_peak)) r_peak <= sample;
         end
         if (w_end) r_hold_cnt <= 32'(HOLDOFF);
         else if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt - 32'd1;
      end
   end

   // Single-entry slot: a post replaces the entry only if it is empty or leaving this cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ev_valid <= 1'b0;
         r_ev_peak  <= '0;
         r_ev_width <= '0;
         r_drop     <= '0;
      end else begin
         if (w_post && (!r_ev_valid || ev_ready)) begin
            r_ev_valid <= 1'b1;
            r_ev_peak  <= r_peak;
            r_ev_width <= r_width;
         end else if (r_ev_valid && ev_ready) begin
            r_ev_valid <= 1'b0;
         end
         if (w_post && r_ev_valid && !ev_ready && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
      end
   end

   assign trig       = r_trig;
   assign busy       = r_busy;
   assign ev_valid   = r_ev_valid;
   assign ev_peak    = r_ev_peak;
   assign ev_width   = r_ev_width;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_threshold_discriminator.sv
// tb/tb_threshold_discriminator.sv - directed self-checking bench for threshold_discriminator
// u_dut uses HOLDOFF=32, u_dut0 uses HOLDOFF=0; both share stimulus.
module tb_threshold_discriminator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample = '0;
   logic [11:0] threshold = '0;
   logic        ev_ready = 1'b0;

   logic        trig, busy, ev_valid;
   logic [11:0] ev_peak;
   logic [15:0] ev_width, drop_count;
   logic        trig0, busy0, ev_valid0;
   logic [11:0] ev_peak0;
   logic [15:0] ev_width0, drop0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   threshold_discriminator u_dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
      .threshold(threshold), .trig(trig), .busy(busy), .ev_valid(ev_valid),
      .ev_ready(ev_ready), .ev_peak(ev_peak), .ev_width(ev_width), .drop_count(drop_count)
   );

   threshold_discriminator #(.HOLDOFF(0)) u_dut0 (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
      .threshold(threshold), .trig(trig0), .busy(busy0), .ev_valid(ev_valid0),
      .ev_ready(ev_ready), .ev_peak(ev_peak0), .ev_width(ev_width0), .drop_count(drop0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int v);
      sample_valid = 1'b1;
      sample = v[11:0];
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sample_valid = 1'b0;
      sample = '0;
      ev_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({trig, busy, ev_valid} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {trig, busy, ev_valid}); end
      total++; if ({ev_peak, ev_width, drop_count} !== 44'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {ev_peak, ev_width, drop_count}); end
      threshold = 12'd100;
      drive(150);
      total++; if ({trig, busy} !== 2'b11) begin bad++; $display("FAIL rst_first_trig got=%b exp=11", {trig, busy}); end
      drive(160);
      #2 reset = 1'b0;
      #1;
      total++; if ({trig, busy, ev_valid} !== 3'b000) begin bad++; $display("FAIL async_reset got=%b exp=000", {trig, busy, ev_valid}); end
      @(negedge clk);
      reset = 1'b1;
      drive(150);
      total++; if (trig !== 1'b1) begin bad++; $display("FAIL rst_fresh_trig got=%b exp=1", trig); end
   endtask

   task automatic test_basic_pulse();
      int n;
      do_reset();
      threshold = 12'd100;
      ev_ready = 1'b1;
      drive(50);
      total++; if ({trig, busy} !== 2'b00) begin bad++; $display("FAIL basic_below got=%b exp=00", {trig, busy}); end
      drive(120);
      total++; if ({trig, busy} !== 2'b11) begin bad++; $display("FAIL basic_trig got=%b exp=11", {trig, busy}); end
      drive(180);
      total++; if (trig !== 1'b0) begin bad++; $display("FAIL basic_trig_one got=%b exp=0", trig); end
      drive(140);
      drive(90);
      total++; if ({ev_valid, ev_peak, ev_width} !== {1'b1, 12'd180, 16'd3}) begin bad++; $display("FAIL basic_event got=%b/%0d/%0d exp=1/180/3", ev_valid, ev_peak, ev_width); end
      sample_valid = 1'b0;
      tick();
      total++; if ({ev_valid, busy} !== 2'b01) begin bad++; $display("FAIL basic_handshake got=%b exp=01", {ev_valid, busy}); end
      n = 1;
      while (busy && n < 100) begin tick(); n++; end
      total++; if (n !== 32) begin bad++; $display("FAIL basic_holdoff_len got=%0d exp=32", n); end
   endtask

   task automatic test_negative_min_width();
      do_reset();
      threshold = -12'sd20;
      ev_ready = 1'b1;
      drive(-30);
      total++; if (trig !== 1'b0) begin bad++; $display("FAIL neg_below got=%b exp=0", trig); end
      drive(-10);
      total++; if (trig !== 1'b1) begin bad++; $display("FAIL neg_trig got=%b exp=1", trig); end
      drive(-40);
      total++; if ({ev_valid, busy} !== 2'b01) begin bad++; $display("FAIL neg_short got=%b exp=01", {ev_valid, busy}); end
      tick();
      total++; if ({ev_valid, drop_count} !== 17'd0) begin bad++; $display("FAIL neg_nodrop got=%b/%0d exp=0/0", ev_valid, drop_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      threshold = 12'd100;
      ev_ready = 1'b0;
      drive(150); drive(170); drive(50);
      total++; if ({ev_valid0, ev_peak0, ev_width0} !== {1'b1, 12'd170, 16'd2}) begin bad++; $display("FAIL bp_first got=%b/%0d/%0d exp=1/170/2", ev_valid0, ev_peak0, ev_width0); end
      drive(130); drive(140); drive(60);
      total++; if (drop0 !== 16'd1) begin bad++; $display("FAIL bp_drop got=%0d exp=1", drop0); end
      total++; if ({ev_valid0, ev_peak0, ev_width0} !== {1'b1, 12'd170, 16'd2}) begin bad++; $display("FAIL bp_held got=%b/%0d/%0d exp=1/170/2", ev_valid0, ev_peak0, ev_width0); end
      sample_valid = 1'b0;
      ev_ready = 1'b1;
      tick();
      total++; if ({ev_valid0, drop0} !== {1'b0, 16'd1}) begin bad++; $display("FAIL bp_accept got=%b/%0d exp=0/1", ev_valid0, drop0); end
   endtask

   task automatic test_holdoff_window();
      logic seen;
      do_reset();
      threshold = 12'd100;
      ev_ready = 1'b1;
      drive(120); drive(130); drive(50);
      seen = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         drive(200);
         if (trig) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL hold_no_trig got=%b exp=0", seen); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy_end got=%b exp=0", busy); end
      drive(200);
      total++; if (trig !== 1'b1) begin bad++; $display("FAIL hold_retrig got=%b exp=1", trig); end
   endtask

   task automatic test_hysteresis();
      do_reset();
      threshold = 12'd100;
      ev_ready = 1'b1;
      drive(120);
      total++; if (trig0 !== 1'b1) begin bad++; $display("FAIL hyst_trig got=%b exp=1", trig0); end
      drive(95);
      drive(110);
`ifdef HYSTERESIS_EN
      total++; if (trig0 !== 1'b0) begin bad++; $display("FAIL hyst_no_retrig got=%b exp=0", trig0); end
      drive(92);
      total++; if ({ev_valid0, ev_peak0, ev_width0} !== {1'b1, 12'd120, 16'd3}) begin bad++; $display("FAIL hyst_event got=%b/%0d/%0d exp=1/120/3", ev_valid0, ev_peak0, ev_width0); end
`else
      total++; if (trig0 !== 1'b1) begin bad++; $display("FAIL hyst_retrig got=%b exp=1", trig0); end
      drive(92);
      total++; if ({ev_valid0, drop0} !== 17'd0) begin bad++; $display("FAIL hyst_noevent got=%b/%0d exp=0/0", ev_valid0, drop0); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_pulse();
      test_negative_min_width();
      test_backpressure();
      test_holdoff_window();
      test_hysteresis();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/threshold_discriminator.md
Name: threshold_discriminator

Overview:
Downstream consumer of the threshold controller's signed threshold word. Compares the ADC sample stream against that threshold and emits a one-cycle trigger on each qualifying crossing. For each qualifying pulse it measures peak amplitude and width (in samples), then applies a dead-time hold-off. Each completed pulse is presented as one event record on a valid/ready interface to the acquisition/readout logic.

Parameters:
N_P, 12, sample and threshold width (signed, two's complement)
W_WIDTH, 16, width of the pulse-width counter and ev_width
HOLDOFF, 32, dead time in clock cycles after pulse end; 0 means no dead time
MIN_WIDTH, 2, minimum pulse width in samples for an event to be emitted; 1 means every pulse is emitted
HYST, 8, hysteresis in LSBs (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_valid  in  1  sample strobe
sample  in  N_P  signed ADC sample
threshold  in  N_P  signed threshold from the threshold controller
trig  out  1  one-cycle trigger pulse
busy  out  1  high in ABOVE or HOLDOFF
ev_valid  out  1  event record valid
ev_ready  in  1  downstream accept
ev_peak  out  N_P  signed peak sample of the pulse
ev_width  out  W_WIDTH  pulse width in valid samples, saturating
drop_count  out  16  events lost to backpressure, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; trig, busy, ev_valid=0; ev_peak, ev_width, drop_count=0; internal counters=0.
- Comparisons are signed and strict: a sample qualifies when sample_valid=1 and sample > level.
- Outputs are registered: trig, ev_valid and busy change one clock after the causing sample edge.
- State IDLE:
  - A qualifying sample against threshold moves the FSM to ABOVE.
  - On that transition, latch fall_level = threshold; threshold changes during a pulse have no effect until the next IDLE.
  - Set peak=sample and width=1.
  - Assert trig for exactly 1 cycle on the next clock.
- State ABOVE, on each sample_valid:
  - If sample > fall_level: width += 1, saturating at 2^W_WIDTH-1; peak = max(peak, sample).
  - Otherwise the pulse ends. The ending sample is not counted.
    - If width >= MIN_WIDTH, post the event.
    - Go to HOLDOFF with the counter loaded to HOLDOFF, or go directly to IDLE if HOLDOFF=0.
    - If width < MIN_WIDTH: no event, no drop count; hold-off still applies.
  - Cycles with sample_valid=0 are ignored.
- State HOLDOFF:
  - Counter decrements once per clock regardless of sample_valid; samples are ignored.
  - Go to IDLE in the cycle the counter reaches 0.
  - A qualifying sample is accepted starting the first clock spent in IDLE.
- Event slot: single entry.
  - Posting loads ev_peak/ev_width and sets ev_valid.
  - ev_valid, ev_peak and ev_width are held stable until a cycle with ev_valid && ev_ready, which clears ev_valid.
  - If a post coincides with a handshake on the slot, the new event loads and ev_valid stays 1.
  - If a post occurs while ev_valid=1 and ev_ready=0, the new event is discarded and drop_count += 1, saturating at 65535.
- trig fires for every crossing, including pulses later discarded by MIN_WIDTH or dropped by backpressure.

Optional Feature:
Macro HYSTERESIS_EN.
- Defined: fall_level = threshold - HYST, computed in N_P+1 bits and clamped at -2^(N_P-1). The pulse ends only when sample <= threshold - HYST.
- Undefined: fall_level = threshold (no hysteresis); HYST is unused.

Test Plan:
1. Reset mid-pulse: threshold=100, samples 150,160, assert reset=0 asynchronously → trig=0, ev_valid=0, busy=0 immediately. After release, state=IDLE and the next sample 150 produces a fresh trig.
2. Basic pulse: threshold=100, samples 50,120,180,140,90, ev_ready=1 → trig 1 cycle after 120; one event with ev_peak=180, ev_width=3; busy stays high for 32 clocks after the sample 90.
3. Negative threshold and MIN_WIDTH: threshold=-20, samples -30,-10,-40 → trig pulses, width=1 < 2 so no ev_valid; drop_count=0.
4. Backpressure: ev_ready=0, HOLDOFF=0, two pulses of width 2 → first event held stable, second dropped, drop_count=1. Then ev_ready=1 → handshake with the first event's values.
5. Hold-off window: HOLDOFF=32, qualifying samples at clocks 5..30 after pulse end produce no trig. A qualifying sample after busy falls gives trig.
6. HYSTERESIS_EN: threshold=100, HYST=8, samples 120,95,110,92 → single pulse; ends at 92; ev_width=3, ev_peak=120. Without the macro the same stimulus ends the pulse at 95, giving ev_width=1 (discarded), with the next pulse starting on 110.
